// File: rtl/clock_module_gate_node.sv
// One node of a daisy-chained clock-distribution tree: power-up/down handshake plus an integrated clock gate.
// Define CLOCK_GATE_BYPASS_EN to pass clock_route_path_in straight through; the handshake is unaffected.
module clock_module_gate_node #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clock,
    input  logic async_resetn,
    output logic parent_request,
    input  logic parent_ready,
    input  logic parent_silent,
    input  logic parent_starting,
    input  logic parent_stopping,
    input  logic child_request,
    output logic child_ready,
    output logic child_silent,
    output logic child_starting,
    output logic child_stopping,
    input  logic clock_route_path_in,
    output logic clock_route_path_out
);

    typedef enum logic [2:0] {SILENT, REQ, ENABLE, READY, DISABLE} state_e;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       gate_en_q, gate_en_d;
    logic       settled;
    logic       unused_status;

    // Upstream silent/starting are informational only.
    assign unused_status = parent_silent ^ parent_starting;

    assign settled = (cnt_q == SETTLE_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            SILENT: begin
                if (child_request) state_d = REQ;
            end
            REQ: begin
                if (!child_request) begin
                    state_d = SILENT;
                end else if (parent_ready && !parent_stopping) begin
                    state_d = ENABLE;
                    cnt_d   = '0;
                end
            end
            ENABLE: begin
                if (settled) state_d = READY;
                else         cnt_d   = cnt_q + 4'd1;
            end
            READY: begin
                if (!child_request || !parent_ready) begin
                    state_d = DISABLE;
                    cnt_d   = '0;
                end
            end
            DISABLE: begin
                if (settled) state_d = SILENT;
                else         cnt_d   = cnt_q + 4'd1;
            end
            default: state_d = SILENT;
        endcase
    end

    assign gate_en_d = (state_d == ENABLE) || (state_d == READY);

    // Outputs are decoded from the next state so they change on the same edge as the state itself.
    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            state_q        <= SILENT;
            cnt_q          <= '0;
            gate_en_q      <= 1'b0;
            parent_request <= 1'b0;
            child_silent   <= 1'b1;
            child_starting <= 1'b0;
            child_ready    <= 1'b0;
            child_stopping <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            gate_en_q      <= gate_en_d;
            parent_request <= (state_d != SILENT);
            child_silent   <= (state_d == SILENT);
            child_starting <= (state_d == REQ) || (state_d == ENABLE);
            child_ready    <= (state_d == READY);
            child_stopping <= (state_d == DISABLE);
        end
    end

`ifdef CLOCK_GATE_BYPASS_EN
    logic unused_gate;
    assign unused_gate          = gate_en_q;
    assign clock_route_path_out = clock_route_path_in;
`else
    logic gate_en_latched;

    // NOTE: this latch is intentional; it only follows gate_en while the routed clock is low,
    // so the AND below can never start or cut a high pulse. Reset closes it immediately.
    always_latch begin
        if (!async_resetn) begin
            gate_en_latched = 1'b0;
        end else if (!clock_route_path_in) begin
            gate_en_latched = gate_en_q;
        end
    end

    assign clock_route_path_out = clock_route_path_in & gate_en_latched;
`endif

endmodule

// File: tb/tb_clock_module_gate_node.sv
// Bench for clock_module_gate_node: a standalone node plus a six-node chain, checked every cycle
// against a phase/timer model, with directed literal checks of the key latencies.
`timescale 1ns/1ps
module tb_clock_module_gate_node;

    localparam int S  = 2;
    localparam int N  = 6;
    localparam int NM = N + 1;   // model index N is the standalone node

    logic clock, async_resetn, route_clk;
    int   n_checks = 0;
    int   n_err    = 0;
    bit   mon_en   = 0;

    // Standalone node.
    logic s_creq, s_pready, s_pstop;
    logic s_preq, s_crdy, s_csil, s_cstart, s_cstop, s_rout;

    clock_module_gate_node #(.SETTLE_CYCLES(S)) u_single (
        .clock                (clock),
        .async_resetn         (async_resetn),
        .parent_request       (s_preq),
        .parent_ready         (s_pready),
        .parent_silent        (1'b0),
        .parent_starting      (1'b0),
        .parent_stopping      (s_pstop),
        .child_request        (s_creq),
        .child_ready          (s_crdy),
        .child_silent         (s_csil),
        .child_starting       (s_cstart),
        .child_stopping       (s_cstop),
        .clock_route_path_in  (route_clk),
        .clock_route_path_out (s_rout)
    );

    // Chain: bit i is the parent side of node i, bit i+1 its child side.
    logic         c_req;
    logic [N:0]   c_rq, c_rdy, c_sil, c_start, c_stop;
    logic [N-1:0] c_rout;

    assign c_rdy[0]   = 1'b1;
    assign c_sil[0]   = 1'b0;
    assign c_start[0] = 1'b0;
    assign c_stop[0]  = 1'b0;
    assign c_rq[N]    = c_req;

    for (genvar i = 0; i < N; i++) begin : g_node
        logic rin, rout;
        if (i == 0) begin : g_root
            assign rin = route_clk;
        end else begin : g_link
            assign rin = g_node[i-1].rout;
        end
        assign c_rout[i] = rout;

        clock_module_gate_node #(.SETTLE_CYCLES(S)) u_node (
            .clock                (clock),
            .async_resetn         (async_resetn),
            .parent_request       (c_rq[i]),
            .parent_ready         (c_rdy[i]),
            .parent_silent        (c_sil[i]),
            .parent_starting      (c_start[i]),
            .parent_stopping      (c_stop[i]),
            .child_request        (c_rq[i+1]),
            .child_ready          (c_rdy[i+1]),
            .child_silent         (c_sil[i+1]),
            .child_starting       (c_start[i+1]),
            .child_stopping       (c_stop[i+1]),
            .clock_route_path_in  (rin),
            .clock_route_path_out (rout)
        );
    end

    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    // Routed clock: 8 ns period, edges on odd ns, never coincident with control-clock edges.
    initial begin
        route_clk = 1'b0;
        #1;
        forever #4 route_clk = ~route_clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Behavioural model ----------------
    typedef enum int {M_IDLE, M_ASK, M_RAMP, M_ON, M_RAMPDN} mphase_e;

    mphase_e m_ph   [NM];
    int      m_left [NM];
    mphase_e nph;
    int      nleft;
    bit      mreq, mrdy, mstp;

    task automatic m_step(input mphase_e ph, input int left, input bit req, input bit rdy,
                          input bit stp, output mphase_e ph_n, output int left_n);
        ph_n   = ph;
        left_n = left;
        case (ph)
            M_IDLE:   if (req) ph_n = M_ASK;
            M_ASK: begin
                if (!req) ph_n = M_IDLE;
                else if (rdy && !stp) begin ph_n = M_RAMP; left_n = S; end
            end
            M_RAMP: begin
                left_n = left - 1;
                if (left_n == 0) ph_n = M_ON;
            end
            M_ON: if (!req || !rdy) begin ph_n = M_RAMPDN; left_n = S; end
            M_RAMPDN: begin
                left_n = left - 1;
                if (left_n == 0) ph_n = M_IDLE;
            end
            default: ph_n = M_IDLE;
        endcase
    endtask

    // {parent_request, child_starting, child_ready, child_stopping, child_silent}
    function automatic logic [4:0] m_out(input mphase_e ph);
        return {ph != M_IDLE, ph == M_ASK || ph == M_RAMP, ph == M_ON, ph == M_RAMPDN, ph == M_IDLE};
    endfunction

    function automatic logic [4:0] dut_out(input int k);
        if (k == N) return {s_preq, s_cstart, s_crdy, s_cstop, s_csil};
        return {c_rq[k], c_start[k+1], c_rdy[k+1], c_stop[k+1], c_sil[k+1]};
    endfunction

    always @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            for (int k = 0; k < NM; k++) begin
                m_ph[k]   <= M_IDLE;
                m_left[k] <= 0;
            end
        end else begin
            for (int k = 0; k < NM; k++) begin
                if (k == N) begin
                    mreq = s_creq; mrdy = s_pready; mstp = s_pstop;
                end else begin
                    mreq = (k == N-1) ? c_req : (m_ph[k+1] != M_IDLE);
                    mrdy = (k == 0) ? 1'b1 : (m_ph[k-1] == M_ON);
                    mstp = (k == 0) ? 1'b0 : (m_ph[k-1] == M_RAMPDN);
                end
                m_step(m_ph[k], m_left[k], mreq, mrdy, mstp, nph, nleft);
                m_ph[k]   <= nph;
                m_left[k] <= nleft;
            end
        end
    end

    // Per-cycle compare: handshake outputs always; routed clock when the gate is settled.
    always @(negedge clock) begin
        if (async_resetn) begin
            for (int k = 0; k < NM; k++)
                check($sformatf("hs_node%0d", k), 32'(dut_out(k)), 32'(m_out(m_ph[k])));
            if (m_ph[N] == M_ON)
                check("single_clk_on", 32'(s_rout), 32'(route_clk));
            else if (m_ph[N] == M_IDLE || m_ph[N] == M_ASK)
                check("single_clk_off", 32'(s_rout), 32'd0);
            for (int k = 0; k < N; k++) begin
                automatic bit all_on = 1'b1;
                for (int j = 0; j <= k; j++)
                    if (m_ph[j] != M_ON) all_on = 1'b0;
                if (all_on)
                    check($sformatf("chain%0d_clk_on", k), 32'(c_rout[k]), 32'(route_clk));
                else if (m_ph[k] == M_IDLE || m_ph[k] == M_ASK)
                    check($sformatf("chain%0d_clk_off", k), 32'(c_rout[k]), 32'd0);
            end
        end
    end

    // Every gated high pulse must be a full routed-clock high phase.
    time s_rise, c_rise;
    always @(posedge s_rout) s_rise = $time;
    always @(negedge s_rout) if (mon_en) check("single_pulse_width", 32'($time - s_rise), 32'd4);
    always @(posedge c_rout[N-1]) c_rise = $time;
    always @(negedge c_rout[N-1]) if (mon_en) check("chain_pulse_width", 32'($time - c_rise), 32'd4);

    // ---------------- Directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic wait_single_ready(input string name);
        for (int i = 0; i < 30 && !s_crdy; i++) tick(1);
        check(name, 32'(s_crdy), 32'd1);
    endtask

    task automatic wait_chain_ready(input string name);
        for (int i = 0; i < 60 && !c_rdy[N]; i++) tick(1);
        check(name, 32'(c_rdy[N]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        async_resetn = 1'b0;
        s_creq = 1'b0; s_pready = 1'b1; s_pstop = 1'b0; c_req = 1'b0;

        #15;
        check("rst_silent", 32'(s_csil), 32'd1);
        check("rst_preq", 32'(s_preq), 32'd0);
        check("rst_hs", 32'({s_cstart, s_crdy, s_cstop}), 32'd0);
        check("rst_clk", 32'(s_rout), 32'd0);
        check("rst_chain_root_preq", 32'(c_rq[0]), 32'd0);
        #9;
        async_resetn = 1'b1;
        mon_en = 1'b1;
        tick(1);

        // Power-up: REQ at edge 1, ENABLE at 2, READY at 4.
        s_creq = 1'b1;
        tick(1);
        check("up_e1_preq", 32'(s_preq), 32'd1);
        check("up_e1_starting", 32'(s_cstart), 32'd1);
        tick(1);
        check("up_e2_starting", 32'(s_cstart), 32'd1);
        tick(1);
        check("up_e3_ready", 32'(s_crdy), 32'd0);
        tick(1);
        check("up_e4_ready", 32'(s_crdy), 32'd1);
        check("up_e4_starting", 32'(s_cstart), 32'd0);

        // Power-down: DISABLE next edge, SILENT two edges later.
        s_creq = 1'b0;
        tick(1);
        check("dn_e1_stopping", 32'(s_cstop), 32'd1);
        check("dn_e1_preq", 32'(s_preq), 32'd1);
        tick(1);
        check("dn_e2_stopping", 32'(s_cstop), 32'd1);
        tick(1);
        check("dn_e3_silent", 32'(s_csil), 32'd1);
        check("dn_e3_preq", 32'(s_preq), 32'd0);
        check("dn_e3_clk", 32'(s_rout), 32'd0);

        // Upstream stopping holds the node in REQ.
        s_pstop = 1'b1;
        s_creq  = 1'b1;
        tick(6);
        check("stop_hold_starting", 32'(s_cstart), 32'd1);
        check("stop_hold_ready", 32'(s_crdy), 32'd0);
        s_pstop = 1'b0;
        tick(1);
        check("stop_rel_e1", 32'(s_crdy), 32'd0);
        tick(1);
        check("stop_rel_e2", 32'(s_crdy), 32'd0);
        tick(1);
        check("stop_rel_e3_ready", 32'(s_crdy), 32'd1);

        // Abort from REQ while upstream is not ready.
        s_creq = 1'b0;
        tick(3);
        s_pready = 1'b0;
        s_creq   = 1'b1;
        tick(2);
        check("abort_req_starting", 32'(s_cstart), 32'd1);
        s_creq = 1'b0;
        tick(1);
        check("abort_silent", 32'(s_csil), 32'd1);
        s_pready = 1'b1;
        s_creq   = 1'b1;
        wait_single_ready("abort_restart_ready");

        // Upstream ready dropping while READY starts DISABLE.
        s_pready = 1'b0;
        tick(1);
        check("prdy_drop_stopping", 32'(s_cstop), 32'd1);
        s_pready = 1'b1;
        tick(2);
        check("prdy_drop_silent", 32'(s_csil), 32'd1);
        wait_single_ready("prdy_drop_restart");

        // Short request drops: DISABLE always completes, then the node restarts.
        for (int k = 1; k <= 5; k++) begin
            s_creq = 1'b0;
            tick(1);
            check($sformatf("gap%0d_stopping", k), 32'(s_cstop), 32'd1);
            if (k > 1) tick(k - 1);
            s_creq = 1'b1;
            wait_single_ready($sformatf("gap%0d_restart", k));
        end

        // Six-node chain: last node READY at edge 24; root request drops at edge 18.
        c_req = 1'b1;
        tick(23);
        check("chain_e23_ready", 32'(c_rdy[N]), 32'd0);
        tick(1);
        check("chain_e24_ready", 32'(c_rdy[N]), 32'd1);
        tick(4);
        c_req = 1'b0;
        tick(17);
        check("chain_e17_root_preq", 32'(c_rq[0]), 32'd1);
        tick(1);
        check("chain_e18_root_preq", 32'(c_rq[0]), 32'd0);

        // Asynchronous reset while everything is READY.
        c_req = 1'b1;
        wait_chain_ready("pre_reset_chain_ready");
        wait_single_ready("pre_reset_single_ready");
        @(posedge clock);
        #6;
        mon_en       = 1'b0;
        async_resetn = 1'b0;
        #1;
        check("ares_silent", 32'(s_csil), 32'd1);
        check("ares_preq", 32'(s_preq), 32'd0);
        check("ares_clk", 32'(s_rout), 32'd0);
        check("ares_chain_root_preq", 32'(c_rq[0]), 32'd0);
        check("ares_chain_clk", 32'(c_rout[N-1]), 32'd0);
        #1;
        async_resetn = 1'b1;
        tick(2);
        mon_en = 1'b1;
        wait_single_ready("post_reset_single_ready");
        wait_chain_ready("post_reset_chain_ready");
        tick(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
